// File: rtl/seq_magnitude_comparator_if.sv
// Start/done handshake bundle between a requester and seq_magnitude_comparator.
// The requester drives the operands and start; the comparator returns status and results.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             gt;
    logic             lt;
    logic             eq;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, gt, lt, eq
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, gt, lt, eq
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, MSB-first, DIGIT bits per cycle.
// Signed operands are handled by flipping both sign bits and comparing unsigned.
module seq_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter int EARLY_EXIT = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    seq_magnitude_comparator_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     cnt_nxt_s;
    logic              found_r;
    logic              found_nxt_s;
    logic              fgt_r;
    logic              fgt_nxt_s;
    logic              busy_r;
    logic              done_r;
    logic              gt_r;
    logic              lt_r;
    logic              eq_r;
    logic              accept_s;
    logic              load_s;
    logic [DIGIT-1:0]  dig_a_s;
    logic [DIGIT-1:0]  dig_b_s;
    logic              dig_neq_s;
    logic              dig_gt_s;
    logic              res_gt_s;
    logic              res_lt_s;
    logic              res_eq_s;

    assign accept_s  = bus.start && ((state_r == IDLE) || (state_r == DONE));
    assign dig_a_s   = a_r[int'(cnt_r)*DIGIT +: DIGIT];
    assign dig_b_s   = b_r[int'(cnt_r)*DIGIT +: DIGIT];
    assign dig_neq_s = (dig_a_s != dig_b_s);
    assign dig_gt_s  = (dig_a_s > dig_b_s);

    // Next-state, digit walk and result selection.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        found_nxt_s = found_r;
        fgt_nxt_s   = fgt_r;
        load_s      = 1'b0;
        res_gt_s    = 1'b0;
        res_lt_s    = 1'b0;
        res_eq_s    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = CMP;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CMP: begin
                if (EARLY_EXIT != 0) begin
                    if (dig_neq_s) begin
                        state_nxt_s = DONE;
                        res_gt_s    = dig_gt_s;
                        res_lt_s    = !dig_gt_s;
                    end else if (cnt_r == CW'(0)) begin
                        state_nxt_s = DONE;
                        res_eq_s    = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r - CW'(1);
                    end
                end else begin
                    // Only the most significant differing digit decides the result.
                    if (!found_r && dig_neq_s) begin
                        found_nxt_s = 1'b1;
                        fgt_nxt_s   = dig_gt_s;
                    end else begin
                        found_nxt_s = found_r;
                    end
                    if (cnt_r == CW'(0)) begin
                        state_nxt_s = DONE;
                        if (found_nxt_s) begin
                            res_gt_s = fgt_nxt_s;
                            res_lt_s = !fgt_nxt_s;
                        end else begin
                            res_eq_s = 1'b1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - CW'(1);
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, operand capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            found_r <= 1'b0;
            fgt_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            gt_r    <= 1'b0;
            lt_r    <= 1'b0;
            eq_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == CMP);
            done_r  <= (state_nxt_s == DONE);
            if (load_s) begin
                a_r     <= {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                b_r     <= {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                cnt_r   <= CW'(NDIG - 1);
                found_r <= 1'b0;
                fgt_r   <= 1'b0;
            end else begin
                cnt_r   <= cnt_nxt_s;
                found_r <= found_nxt_s;
                fgt_r   <= fgt_nxt_s;
            end
            if (state_nxt_s == DONE) begin
                gt_r <= res_gt_s;
                lt_r <= res_lt_s;
                eq_r <= res_eq_s;
            end else begin
                gt_r <= gt_r;
                lt_r <= lt_r;
                eq_r <= eq_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.gt   = gt_r;
    assign bus.lt   = lt_r;
    assign bus.eq   = eq_r;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator: default build and an EARLY_EXIT=0 build.
module tb_seq_magnitude_comparator;
    logic clk = 1'b0;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator_if #(.WIDTH(8)) i0 ();
    seq_magnitude_comparator_if #(.WIDTH(8)) i1 ();

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(i0.slave));
    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(i1.slave));

    // Launch one compare on u0; returns cycles from accepting edge to done and {gt,lt,eq}.
    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output int lat, output logic [2:0] res);
        @(negedge clk);
        i0.a = a; i0.b = b; i0.signed_mode = sm; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        lat = 0;
        while (!i0.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {i0.gt, i0.lt, i0.eq};
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output int lat, output logic [2:0] res);
        @(negedge clk);
        i1.a = a; i1.b = b; i1.signed_mode = sm; i1.start = 1'b1;
        @(negedge clk);
        i1.start = 1'b0;
        lat = 0;
        while (!i1.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = {i1.gt, i1.lt, i1.eq};
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        i0.start = 1'b0; i0.a = 8'h00; i0.b = 8'h00; i0.signed_mode = 1'b0;
        i1.start = 1'b0; i1.a = 8'h00; i1.b = 8'h00; i1.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {i0.busy, i0.done, i0.gt, i0.lt, i0.eq};
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL reset_u0 got %b want 00000", obs); end
        obs = {i1.busy, i1.done, i1.gt, i1.lt, i1.eq};
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL reset_u1 got %b want 00000", obs); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        obs = {i0.busy, i0.done, i0.gt, i0.lt, i0.eq};
        compared++;
        if (obs !== 5'b00000) begin mismatched++; $display("FAIL post_reset_idle got %b want 00000", obs); end
    endtask

    task automatic test_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic sm, input int exp_lat, input logic [2:0] exp_res);
        int         lat;
        logic [2:0] res;
        run0(a, b, sm, lat, res);
        compared++;
        if (lat !== exp_lat) begin mismatched++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
        compared++;
        if (res !== exp_res) begin mismatched++; $display("FAIL %s_result gt/lt/eq got %b want %b", name, res, exp_res); end
    endtask

    task automatic test_no_early_exit(input string name, input logic [7:0] a, input logic [7:0] b,
                                      input logic sm, input logic [2:0] exp_res);
        int         lat;
        logic [2:0] res;
        run1(a, b, sm, lat, res);
        compared++;
        if (lat !== 4) begin mismatched++; $display("FAIL %s_latency got %0d want 4", name, lat); end
        compared++;
        if (res !== exp_res) begin mismatched++; $display("FAIL %s_result gt/lt/eq got %b want %b", name, res, exp_res); end
    endtask

    task automatic test_start_while_busy();
        int   lat;
        logic extra_done;
        @(negedge clk);
        i0.a = 8'h5A; i0.b = 8'h5A; i0.signed_mode = 1'b0; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        @(negedge clk);
        i0.a = 8'hFF; i0.b = 8'h00; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        lat = 2;
        while (!i0.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if (lat !== 4) begin mismatched++; $display("FAIL ignore_latency got %0d want 4", lat); end
        compared++;
        if ({i0.gt, i0.lt, i0.eq} !== 3'b001) begin
            mismatched++; $display("FAIL ignore_result gt/lt/eq got %b want 001", {i0.gt, i0.lt, i0.eq});
        end
        extra_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            extra_done = extra_done | i0.done | i0.busy;
        end
        compared++;
        if (extra_done !== 1'b0) begin mismatched++; $display("FAIL ignore_no_restart got %b want 0", extra_done); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        i0.a = 8'h80; i0.b = 8'h7F; i0.signed_mode = 1'b0; i0.start = 1'b1;
        @(negedge clk);
        i0.a = 8'h00; i0.b = 8'h01;
        compared++;
        if (i0.busy !== 1'b1) begin mismatched++; $display("FAIL b2b_busy1 got %b want 1", i0.busy); end
        @(negedge clk);
        compared++;
        if ({i0.done, i0.busy, i0.gt} !== 3'b101) begin
            mismatched++; $display("FAIL b2b_first_done done/busy/gt got %b want 101", {i0.done, i0.busy, i0.gt});
        end
        @(negedge clk);
        i0.start = 1'b0;
        compared++;
        if ({i0.busy, i0.done, i0.gt} !== 3'b101) begin
            mismatched++; $display("FAIL b2b_restart busy/done/gt got %b want 101", {i0.busy, i0.done, i0.gt});
        end
        lat = 0;
        while (!i0.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if (lat !== 4) begin mismatched++; $display("FAIL b2b_second_latency got %0d want 4", lat); end
        compared++;
        if ({i0.gt, i0.lt, i0.eq} !== 3'b010) begin
            mismatched++; $display("FAIL b2b_second_result gt/lt/eq got %b want 010", {i0.gt, i0.lt, i0.eq});
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        i0.a = 8'h33; i0.b = 8'h33; i0.signed_mode = 1'b0; i0.start = 1'b1;
        @(negedge clk);
        i0.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        compared++;
        if ({i0.busy, i0.done, i0.gt, i0.lt, i0.eq} !== 5'b00000) begin
            mismatched++; $display("FAIL midreset_outputs got %b want 00000", {i0.busy, i0.done, i0.gt, i0.lt, i0.eq});
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_done = saw_done | i0.done;
        end
        compared++;
        if (saw_done !== 1'b0) begin mismatched++; $display("FAIL midreset_no_done got %b want 0", saw_done); end
        test_vec("after_midreset", 8'h5A, 8'h5B, 1'b0, 4, 3'b010);
    endtask

    initial begin
        test_reset();
        test_vec("unsigned_80_7f", 8'h80, 8'h7F, 1'b0, 1, 3'b100);
        test_vec("signed_80_7f",   8'h80, 8'h7F, 1'b1, 1, 3'b010);
        test_vec("equal_5a",       8'h5A, 8'h5A, 1'b0, 4, 3'b001);
        test_vec("lastdig_5a_5b",  8'h5A, 8'h5B, 1'b0, 4, 3'b010);
        test_vec("signed_ff_00",   8'hFF, 8'h00, 1'b1, 1, 3'b010);
        test_vec("unsigned_ff_00", 8'hFF, 8'h00, 1'b0, 1, 3'b100);
        test_vec("mid_digit_34_24", 8'h34, 8'h24, 1'b0, 2, 3'b100);
        test_no_early_exit("noee_c0_00", 8'hC0, 8'h00, 1'b0, 3'b100);
        test_no_early_exit("noee_40_83", 8'h40, 8'h83, 1'b0, 3'b010);
        test_no_early_exit("noee_equal", 8'h96, 8'h96, 1'b0, 3'b001);
        test_no_early_exit("noee_signed_80_01", 8'h80, 8'h01, 1'b1, 3'b010);
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator that generalises the single-bit gt/lt/eq compare to WIDTH-bit operands. It processes operands MSB-first, DIGIT bits per cycle, supports signed or unsigned interpretation per operation, and can terminate early at the first differing digit. It sits beside datapath blocks that need area-cheap compares, such as sorters and limit checkers, and talks to them through a start/done handshake.

## Interface
Parameters:
- WIDTH, default 8, operand width in bits; must be ≥ 2.
- DIGIT, default 2, bits compared per cycle; WIDTH % DIGIT == 0 is required. NDIG = WIDTH/DIGIT.
- EARLY_EXIT, default 1. When 1, the block finishes at the first unequal digit. When 0, it always takes NDIG compare cycles.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a compare; accepted only when busy=0.
- a  in  WIDTH  operand A; sampled on the accepting edge only.
- b  in  WIDTH  operand B; sampled on the accepting edge only.
- signed_mode  in  1  1 selects two's-complement compare; sampled with the operands.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result registers update.
- gt  out  1  registered result, A > B.
- lt  out  1  registered result, A < B.
- eq  out  1  registered result, A == B.

## Operation
- FSM states: IDLE, CMP, DONE. The reset state is IDLE.
- Reset values: busy=0, done=0, gt=0, lt=0, eq=0, digit counter=0, and the operand registers are cleared.
- Accept rule: start=1 with state IDLE or DONE is accepted.
  - The accepting edge captures a_r = a and b_r = b, each with its MSB XORed with signed_mode. This sign-flip turns the signed compare into an unsigned compare.
  - The same edge sets cnt = NDIG-1, clears the internal first-difference flag, and moves the FSM to CMP.
- start while busy=1 is ignored. Operands must not be re-sampled.
- CMP: each cycle compares digit cnt, which is a_r[cnt*DIGIT +: DIGIT] against the matching digit of b_r, as unsigned values.
  - With EARLY_EXIT=1, an unequal digit latches gt or lt and the FSM goes to DONE.
  - An equal digit with cnt==0 latches eq and the FSM goes to DONE.
  - Otherwise cnt decrements and the FSM stays in CMP.
  - With EARLY_EXIT=0, the first unequal digit, the most significant one, is recorded in the flag and later digits do not override it. The FSM goes to DONE only after cnt==0. The result is the recorded difference, or eq if no difference was found.
- Result registers update on the edge that enters DONE. Exactly one of gt/lt/eq is then 1.
- Results hold until the next entry to DONE. They are not cleared on start.
- DONE: done=1 and busy=0 for one cycle. The FSM then goes to IDLE, or directly to CMP if start is accepted in that cycle.
- Reset mid-operation: the FSM returns to IDLE with all outputs at their reset values. No done pulse is produced for the aborted compare.

## Timing
- busy=1 exactly in state CMP.
- Latency: start is accepted at edge E0 and the compare resolves on digit j (j=1 is the most significant digit). done is high in the cycle after edge E_j.
  - The latency is j cycles.
  - Minimum is 1, worst case is NDIG.
  - With EARLY_EXIT=0 the latency is always NDIG.
- Back-to-back: start held high during DONE gives a new compare with no idle cycle. Throughput is 1 compare per latency+1 cycles.
- done and the result registers change on the same edge.
- signed_mode applies only to the operation it was sampled with.

## Test plan
- Reset: hold rst_n=0 for 2 cycles. Check busy=0, done=0, gt=0, lt=0, eq=0. Release with no start; outputs stay unchanged.
- Defaults (WIDTH=8, DIGIT=2, EARLY_EXIT=1):
  - Unsigned: a=0x80, b=0x7F, signed_mode=0 -> done 1 cycle after the accepting edge, gt=1.
  - Same operands with signed_mode=1 -> done after 1 cycle, lt=1.
- Equal and last-digit cases: a=b=0x5A -> done after 4 cycles, eq=1. a=0x5A, b=0x5B -> done after 4 cycles, lt=1. a=0xFF, b=0x00 in signed mode -> lt=1, since -1 < 0.
- EARLY_EXIT=0: a=0xC0, b=0x00 -> done after exactly 4 cycles with gt=1. The later equal digits do not override the result.
- Handshake:
  - start pulsed during CMP with different operands -> ignored; the first result is unchanged.
  - start held through DONE -> the next compare begins immediately and busy rises on the following cycle.
- Reset mid-compare: start with a=b=0x33, then drive rst_n=0 at cycle 2 -> next cycle busy=0, no done pulse, results 0. A subsequent compare works normally.
